if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the RISC-V core: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and presents {pc, instruction} pairs to decode with a valid/ready handshake. It sits directly upstream of the next-PC/operand muxing and consumes the redirect target those muxes produce for branches and jumps. At most one fetch is outstanding; responses return in order.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word-aligned)
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  reset; synchronous and active-high
- redirect_valid  in  1  taken branch/jump; load redirect_pc as next fetch address
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address (word-aligned)
- imem_rsp_valid  in  1  response data valid (one pulse per accepted request)
- imem_rsp_data  in  32  fetched instruction
- if_valid  out  1  {if_pc, if_instr} valid to decode
- if_ready  in  1  decode accepts this cycle
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD. All outputs registered.
- IDLE: one cycle after reset, -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT; request address/valid held stable until accepted.
- WAIT: on imem_rsp_valid, capture if_pc=pc, if_instr=imem_rsp_data, -> HOLD.
- HOLD: if_valid=1, payload stable. On if_valid&if_ready: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), -> REQ.
- DRAIN: one stale response in flight; on imem_rsp_valid discard data, -> REQ.
- Redirect (priority over every other event in the same cycle): pc<=redirect_pc & ~3, then
  - IDLE/REQ without acceptance -> REQ (new address driven next cycle)
  - REQ with imem_req_ready same cycle (old address accepted) -> DRAIN
  - WAIT without rsp -> DRAIN; WAIT with rsp same cycle -> REQ, data discarded
  - DRAIN with rsp same cycle -> REQ; without -> stay DRAIN (latest redirect wins)
  - HOLD -> REQ; if_valid drops next cycle even if if_ready was high (no pc+4)
- imem_rsp_valid in IDLE/REQ/HOLD is ignored (protocol error, no state change).

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
- rst asserted mid-operation overrides everything including redirect; in-flight response after reset is ignored (memory shares rst).
- First request: imem_req_valid high in 2nd cycle after rst deasserts.
- Request accepted in cycle N, response in N+k (k>=1): if_valid high in N+k+1.
- Decode handshake in cycle M: next request issued in M+1. Peak throughput one instruction per 3 cycles with k=1.
- Redirect in cycle R: imem_req_addr=redirect target no later than R+1 unless draining; no wrong-path instruction ever presented after R.

## Structure
- Shared riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, fetch state enum (IDLE, REQ, WAIT, DRAIN, HOLD).
- One sub-module: pc_reg (PC register with synchronous reset to RESET_PC, load-redirect, increment-by-4 enables).
- FSM, payload registers and handshake logic in top.

## Test plan
- Reset, imem k=1 always ready, decode always ready -> requests at 0x0, 0x4, 0x8; if_pc matches, if_instr equals memory contents, one instr per 3 cycles.
- imem_req_ready low 3 cycles -> imem_req_addr/valid held stable; decode holds if_ready low 4 cycles -> payload stable, no new request.
- redirect_pc=0x103 while WAIT (k=3) -> stale response dropped, next request addr 0x100, if_pc=0x100.
- redirect in HOLD simultaneous with if_ready -> no pc+4, next request = redirect target, if_valid low next cycle.
- RESET_PC=0xFFFF_FFFC -> second fetch address wraps to 0x0.
- rst pulsed during WAIT, response arrives after -> ignored; fetch restarts at RESET_PC, outputs at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP encoding,
// fetch FSM state encoding and an address alignment helper.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter: synchronous reset to RESET_PC, redirect load (word-aligned)
// with priority over the sequential +4 increment.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_next
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // next PC selection; the increment wraps naturally at 2^32
    always_comb begin
        w_pc_next = r_pc;
        if (i_load) begin
            w_pc_next = word_align(i_load_pc);
        end else if (i_inc) begin
            w_pc_next = r_pc + 32'd4;
        end else begin
            w_pc_next = r_pc;
        end
    end

    // PC state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding word fetch from imem and
// {pc, instr} hand-off to decode, with branch/jump redirect handling.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            w_load;
    logic            w_inc;
    logic            w_capture;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_next;

    logic            r_req_valid;
    logic [XLEN-1:0] r_req_addr;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_pc (redirect_pc),
        .i_inc     (w_inc),
        .o_pc      (w_pc),
        .o_pc_next (w_pc_next)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state and PC control; a redirect dominates every other event
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load       = redirect_valid;
                w_state_next = S_REQ;
            end
            S_REQ: begin
                w_load = redirect_valid;
                if (imem_req_ready) begin
                    // old address already accepted: its response must be drained
                    w_state_next = redirect_valid ? S_DRAIN : S_WAIT;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_load       = 1'b1;
                    w_state_next = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_DRAIN: begin
                w_load       = redirect_valid;
                w_state_next = imem_rsp_valid ? S_REQ : S_DRAIN;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_REQ;
                end else if (r_if_valid && if_ready) begin
                    w_inc        = 1'b1;
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // registered request and decode-side outputs, derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_pc     <= 32'h0000_0000;
            r_if_instr  <= INSTR_NOP;
        end else begin
            r_req_valid <= (w_state_next == S_REQ);
            r_req_addr  <= w_pc_next;
            r_if_valid  <= (w_state_next == S_HOLD);
            if (w_capture) begin
                r_if_pc    <= w_pc;
                r_if_instr <= imem_rsp_data;
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instr       = r_if_instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// traffic checked against a transaction-level program-order model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_instr;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    // Second instance with a top-of-memory reset PC; it mirrors the main
    // instance's inputs, so its timing matches when no redirects are issued.
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(w_if_valid), .if_ready(if_ready),
        .if_pc(w_if_pc), .if_instr(w_if_instr)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    logic [31:0] model_pc;
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          k_lat;
    logic        redir_last;
    logic        force_rsp;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive memory response, check program-order invariants, advance model.
    task automatic tick();
        imem_rsp_valid = force_rsp || (mem_pend && (mem_cnt == 1));
        imem_rsp_data  = imem_rsp_valid ? mem_of(mem_addr) : $urandom;
        @(negedge clk);
        if (imem_req_valid === 1'b1) begin
            n_vec++;
            if (imem_req_addr !== model_pc) begin
                n_err++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, model_pc);
            end
            n_vec++;
            if (mem_pend !== 1'b0) begin
                n_err++;
                $display("FAIL single_outstanding cyc=%0d got req_valid=1 exp=0 while response pending", cyc);
            end
        end
        if (if_valid === 1'b1) begin
            n_vec++;
            if (if_pc !== model_pc || if_instr !== mem_of(model_pc)) begin
                n_err++;
                $display("FAIL payload cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, if_pc, if_instr, model_pc, mem_of(model_pc));
            end
        end
        if (redir_last) begin
            n_vec++;
            if (if_valid !== 1'b0) begin
                n_err++;
                $display("FAIL if_valid_after_redirect cyc=%0d got=%b exp=0", cyc, if_valid);
            end
        end
        redir_last = (redirect_valid === 1'b1) && (rst === 1'b0);
        if (rst === 1'b1) begin
            model_pc = 32'h0000_0000;
            mem_pend = 1'b0;
        end else begin
            if (redirect_valid) begin
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (if_valid && if_ready) begin
                model_pc = model_pc + 32'd4;
                hs_cnt++;
            end
            if (imem_rsp_valid) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_cnt  = k_lat;
                mem_addr = imem_req_addr;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (imem_req_valid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_ifv(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (if_valid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; if_ready = 1'b0; force_rsp = 1'b0; k_lat = 1;
        repeat (3) tick();
        n_vec++;
        if ({imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr} !==
            {1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, NOP}) begin
            n_err++;
            $display("FAIL reset_values got rv=%b ra=%h iv=%b pc=%h in=%h", imem_req_valid,
                     imem_req_addr, if_valid, if_pc, if_instr);
        end
        rst = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL first_cycle_idle got req_valid=%b exp=0", imem_req_valid);
        end
        tick();
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL first_request got valid=%b addr=%h exp valid=1 addr=0", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stream();
        int req_cyc [3];
        logic [31:0] req_a [3];
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        int nr = 0;
        int nh = 0;
        imem_req_ready = 1'b1; if_ready = 1'b1; k_lat = 1;
        do_reset();
        for (int i = 0; i < 40 && (nr < 3 || nh < 3); i++) begin
            if (imem_req_valid && nr < 3) begin req_cyc[nr] = cyc; req_a[nr] = imem_req_addr; nr++; end
            if (if_valid && if_ready && nh < 3) begin pcs[nh] = if_pc; ins[nh] = if_instr; nh++; end
            tick();
        end
        n_vec++;
        if (nr != 3 || nh != 3) begin
            n_err++; $display("FAIL stream_timeout got reqs=%0d instrs=%0d exp 3/3", nr, nh);
        end else begin
            for (int j = 0; j < 3; j++) begin
                logic [31:0] exp_a;
                exp_a = 32'd4 * j;
                n_vec++;
                if (req_a[j] !== exp_a || pcs[j] !== exp_a || ins[j] !== mem_of(exp_a)) begin
                    n_err++;
                    $display("FAIL stream_%0d got addr=%h pc=%h instr=%h exp %h/%h/%h", j, req_a[j],
                             pcs[j], ins[j], exp_a, exp_a, mem_of(exp_a));
                end
                if (j > 0) begin
                    n_vec++;
                    if (req_cyc[j] - req_cyc[j-1] != 3) begin
                        n_err++; $display("FAIL stream_spacing got=%0d exp=3", req_cyc[j] - req_cyc[j-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] a0, p0, i0;
        imem_req_ready = 1'b0; if_ready = 1'b0; k_lat = 1;
        do_reset();
        wait_req(5, ok);
        a0 = imem_req_addr;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin
                n_err++; $display("FAIL req_hold got valid=%b addr=%h exp 1/%h", imem_req_valid, imem_req_addr, a0);
            end
        end
        imem_req_ready = 1'b1;
        tick();
        wait_ifv(6, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL stall_timeout got if_valid=0 exp=1"); end
        p0 = if_pc; i0 = if_instr;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (if_valid !== 1'b1 || if_pc !== p0 || if_instr !== i0 || imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL decode_hold got iv=%b pc=%h in=%h rv=%b exp 1/%h/%h/0", if_valid, if_pc,
                         if_instr, imem_req_valid, p0, i0);
            end
        end
        if_ready = 1'b1;
        tick();
        n_vec++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== p0 + 32'd4) begin
            n_err++;
            $display("FAIL after_handshake got iv=%b rv=%b addr=%h exp 0/1/%h", if_valid, imem_req_valid,
                     imem_req_addr, p0 + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        imem_req_ready = 1'b1; if_ready = 1'b1; k_lat = 3;
        do_reset();
        wait_req(5, ok);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_no_req got req_valid=%b exp=0", imem_req_valid);
        end
        wait_req(10, ok);
        n_vec++;
        if (!ok || imem_req_addr !== 32'h0000_0100) begin
            n_err++; $display("FAIL redirect_req got ok=%b addr=%h exp 1/00000100", ok, imem_req_addr);
        end
        wait_ifv(10, ok);
        n_vec++;
        if (!ok || if_pc !== 32'h0000_0100 || if_instr !== mem_of(32'h0000_0100)) begin
            n_err++; $display("FAIL redirect_payload got ok=%b pc=%h instr=%h exp pc=00000100", ok, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_hold();
        bit ok;
        logic [31:0] tgt;
        if_ready = 1'b0; k_lat = 1;
        wait_ifv(12, ok);
        tgt = $urandom;
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = tgt;
        tick();
        redirect_valid = 1'b0;
        n_vec++;
        if (!ok || if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== (tgt & 32'hFFFF_FFFC)) begin
            n_err++;
            $display("FAIL hold_redirect got ok=%b iv=%b rv=%b addr=%h exp 1/0/1/%h", ok, if_valid,
                     imem_req_valid, imem_req_addr, tgt & 32'hFFFF_FFFC);
        end
        wait_ifv(10, ok);
        n_vec++;
        if (!ok || if_pc !== (tgt & 32'hFFFF_FFFC)) begin
            n_err++; $display("FAIL hold_redirect_pc got ok=%b pc=%h exp %h", ok, if_pc, tgt & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wa [2];
        logic [31:0] ma [2];
        logic [31:0] wpc;
        int nw = 0;
        int nm = 0;
        bit seen = 1'b0;
        imem_req_ready = 1'b1; if_ready = 1'b1; k_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && nw < 2; i++) begin
            if (w_req_valid && nw < 2) begin wa[nw] = w_req_addr; nw++; end
            if (w_if_valid && !seen) begin wpc = w_if_pc; seen = 1'b1; end
            tick();
        end
        n_vec++;
        if (nw != 2 || !seen || wa[0] !== 32'hFFFF_FFFC || wa[1] !== 32'h0000_0000 || wpc !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL reset_pc_wrap got n=%0d a0=%h a1=%h pc=%h exp FFFFFFFC/00000000/FFFFFFFC", nw,
                     wa[0], wa[1], wpc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && nm < 2; i++) begin
            if (imem_req_valid && nm < 2) begin ma[nm] = imem_req_addr; nm++; end
            tick();
        end
        n_vec++;
        if (nm != 2 || ma[0] !== 32'hFFFF_FFFC || ma[1] !== 32'h0000_0000) begin
            n_err++; $display("FAIL redirect_wrap got n=%0d a0=%h a1=%h exp FFFFFFFC/00000000", nm, ma[0], ma[1]);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        imem_req_ready = 1'b1; if_ready = 1'b1; k_lat = 3;
        do_reset();
        wait_req(5, ok);
        tick();
        tick();
        rst = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0440;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        n_vec++;
        if ({imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr} !==
            {1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, NOP}) begin
            n_err++;
            $display("FAIL mid_reset_values got rv=%b ra=%h iv=%b pc=%h in=%h", imem_req_valid,
                     imem_req_addr, if_valid, if_pc, if_instr);
        end
        force_rsp = 1'b1;
        tick();
        force_rsp = 1'b0;
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000 || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_rsp_ignored got rv=%b addr=%h iv=%b exp 1/00000000/0", imem_req_valid,
                     imem_req_addr, if_valid);
        end
        wait_ifv(10, ok);
        n_vec++;
        if (!ok || if_pc !== 32'h0000_0000 || if_instr !== mem_of(32'h0000_0000)) begin
            n_err++; $display("FAIL restart_fetch got ok=%b pc=%h instr=%h exp pc=0", ok, if_pc, if_instr);
        end
    endtask

    task automatic test_random();
        int hs0;
        imem_req_ready = 1'b1; if_ready = 1'b1; k_lat = 1;
        do_reset();
        hs0 = hs_cnt;
        for (int i = 0; i < 2000; i++) begin
            imem_req_ready = ($urandom % 4) != 0;
            if_ready       = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            k_lat          = $urandom_range(1, 4);
            tick();
        end
        redirect_valid = 1'b0;
        n_vec++;
        if (hs_cnt - hs0 <= 100) begin
            n_err++; $display("FAIL random_progress got handshakes=%0d exp >100", hs_cnt - hs0);
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; if_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        model_pc = 32'h0; mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        k_lat = 1; redir_last = 1'b0; force_rsp = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
